// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding, common to receive and transmit stages.
package uart_pkg;

  localparam int UART_OVERSAMPLE  = 16;
  localparam int UART_SAMPLE_TICK = 7;
  localparam int UART_DATA_BITS   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module uart_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input; the reset level matches the idle line.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: 16x oversampled, mid-bit sampling, byte + strobe + framing error out.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SAMPLE_TICK = UART_SAMPLE_TICK
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      sck_rising_edge,
  input  logic                      sin,
  output logic                      busy,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_data_valid,
  output logic                      rx_error
);

  localparam int             TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]  TCNT_SAMP = TW'(SAMPLE_TICK);
  localparam logic [TW-1:0]  TCNT_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]     BIDX_LAST = 3'(UART_DATA_BITS - 1);

  uart_rx_state_t            state_r;
  logic [TW-1:0]             tcnt_r;
  logic [2:0]                bidx_r;
  logic [UART_DATA_BITS-1:0] sh_r;
  logic                      s_s;
  logic                      s_d_r;
  logic                      fall_s;
  logic                      sample_s;

  uart_sync_2ff #(.RESET_VAL(1'b1)) u_sync_sin (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sin),
    .q     (s_s)
  );

  // Delayed copy of the synchronized line for falling-edge detection.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s_d_r <= 1'b1;
    end else begin
      s_d_r <= s_s;
    end
  end

  assign fall_s   = s_d_r & ~s_s;
  assign sample_s = sck_rising_edge & (tcnt_r == TCNT_SAMP);

  // Frame sequencing: state, tick counter, bit index and busy flag.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r <= IDLE;
      tcnt_r  <= '0;
      bidx_r  <= 3'd0;
      busy    <= 1'b0;
    end else if (!en) begin
      state_r <= IDLE;
      tcnt_r  <= '0;
      bidx_r  <= 3'd0;
      busy    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          tcnt_r <= '0;
          bidx_r <= 3'd0;
          // A tick coinciding with detection is deliberately not counted.
          if (fall_s) begin
            state_r <= START;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        START: begin
          if (sck_rising_edge) begin
            if (sample_s && s_s) begin
              state_r <= IDLE;
              tcnt_r  <= '0;
              busy    <= 1'b0;
            end else if (tcnt_r == TCNT_LAST) begin
              state_r <= DATA;
              tcnt_r  <= '0;
              bidx_r  <= 3'd0;
            end else begin
              tcnt_r  <= tcnt_r + TW'(1);
            end
          end
        end
        DATA: begin
          if (sck_rising_edge) begin
            if (tcnt_r == TCNT_LAST) begin
              tcnt_r <= '0;
              if (bidx_r == BIDX_LAST) begin
                state_r <= STOP;
              end else begin
                bidx_r  <= bidx_r + 3'd1;
              end
            end else begin
              tcnt_r <= tcnt_r + TW'(1);
            end
          end
        end
        STOP: begin
          // Return as soon as the stop bit is sampled so back-to-back frames are caught.
          if (sample_s) begin
            state_r <= IDLE;
            tcnt_r  <= '0;
            bidx_r  <= 3'd0;
            busy    <= 1'b0;
          end else if (sck_rising_edge) begin
            tcnt_r  <= tcnt_r + TW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          tcnt_r  <= '0;
          bidx_r  <= 3'd0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Shift register and output capture; outputs only change on a completed frame.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sh_r          <= '0;
      rx_data       <= '0;
      rx_error      <= 1'b0;
      rx_data_valid <= 1'b0;
    end else begin
      rx_data_valid <= 1'b0;
      if (en && sample_s && (state_r == DATA)) begin
        sh_r <= {s_s, sh_r[UART_DATA_BITS-1:1]};
      end else if (en && sample_s && (state_r == STOP)) begin
        rx_data       <= sh_r;
        rx_error      <= ~s_s;
        rx_data_valid <= 1'b1;
      end else begin
        sh_r <= sh_r;
      end
    end
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel receive stage of the UART peripheral. Consumes the serial line `sin` and the 16x-oversampling tick `sck_rising_edge` from the clock-divider stage. Delivers 8N1 frames as a byte plus a one-cycle valid strobe, a framing-error flag and a busy indication to the register/bus side.

## Interface
- OVERSAMPLE, 16: `sck_rising_edge` pulses per bit period.
- SAMPLE_TICK, 7: tick index, 0-based within a bit period, at which the line is sampled; must be < OVERSAMPLE.
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset rst_n, asynchronous, active-high.
- en  input  1  receiver enable; low forces IDLE.
- sck_rising_edge  input  1  one-`clk`-wide tick at 16x baud.
- sin  input  1  serial input, idle high, asynchronous to `clk`.
- busy  output  1  high while a frame is in progress.
- rx_data  output  8  last received byte, LSB first on the line.
- rx_data_valid  output  1  one-cycle strobe when a frame completes.
- rx_error  output  1  stop bit of the last completed frame was 0.

## Operation
- `sin` passes through a 2-flop synchronizer; both flops reset to 1. `s` is the synchronized value; `s_d` is `s` delayed one cycle.
- The 4-bit tick counter `tcnt` and the 3-bit bit index `bidx` advance only on cycles with `sck_rising_edge`=1.
- States: IDLE, START, DATA, STOP.
  - IDLE: `tcnt`=0. A falling edge (`s_d`=1, `s`=0) with `en`=1 moves to START. A line held low does not retrigger; this covers break.
  - START: on tick with `tcnt`==SAMPLE_TICK, if `s`=1 the start is false: return to IDLE with no strobe. Otherwise continue. On the tick with `tcnt`==OVERSAMPLE-1, clear `tcnt`, set `bidx`=0 and go to DATA.
  - DATA: on the sample tick, shift `s` into the MSB of shift register `sh` (LSB-first reception). At the end of each bit period, `bidx`++. After the bit with `bidx`==7, go to STOP.
  - STOP: on the sample tick, load `rx_data`<=`sh`, `rx_error`<=~`s`, pulse `rx_data_valid`, and go directly to IDLE. The remainder of the stop bit is not waited for.
- `busy` = (state != IDLE), registered with the state.
- `rx_data_valid` fires for framing-error frames too, with `rx_error`=1. `rx_data` and `rx_error` hold their values until the next completed frame.
- `en` deasserted in any state: next cycle state=IDLE and counters cleared. No strobe is produced; `rx_data`/`rx_error` are unchanged.
- Reset (any state): state=IDLE, `tcnt`=0, `bidx`=0, `sh`=0, `rx_data`=0x00, `rx_data_valid`=0, `rx_error`=0, `busy`=0.

## Timing
- The falling edge on `sin` reaches `s` after 2 clk; START is entered 1 clk later.
- Sampling happens at tick SAMPLE_TICK of each 16-tick bit period. Sample points relative to start detection:
  - start bit: tick 7
  - data bit n: tick 16·(n+1)+7
  - stop bit: tick 151
- `rx_data_valid`, `rx_data` and `rx_error` change in the clk cycle following the posedge that registers stop-bit tick 151. `busy` falls in the same cycle.
- A new falling edge is accepted from the first cycle back in IDLE. Back-to-back frames with a full 16-tick stop bit therefore never lose data.
- Ticks arriving while in IDLE are ignored. A tick in the same cycle as start detection is not counted.
- Width rules:
  - `tcnt` wraps from 15 to 0 only at bit boundaries.
  - `bidx` never exceeds 7.
  - No arithmetic beyond increment.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t`
  - constants `UART_OVERSAMPLE=16`, `UART_SAMPLE_TICK=7`, `UART_DATA_BITS=8`, shared with the transmitter
- Sub-module `uart_sync_2ff`: parameterized reset value, reused for `sin`.
- Remaining logic: one FSM `always_ff` plus a datapath `always_ff` in `uart_receiver`.

## Test plan
- Divider 0x04, `en`=1, frame 0/0xA5/1 → exactly one `rx_data_valid` pulse; `rx_data`=0xA5; `rx_error`=0; `busy` high from start detection to strobe.
- Frames 0x00, 0xFF, 0x5A back-to-back with no idle gap → three strobes in order, data 0x00, 0xFF, 0x5A, `rx_error`=0 each.
- Frame 0x3C with stop bit 0 → strobe with `rx_data`=0x3C, `rx_error`=1. Following good frame 0x11 → `rx_error`=0.
- `sin` low for 4 ticks then high (glitch) → no strobe; `busy` returns to 0 after the tick-7 sample; `rx_data` unchanged.
- Drop `en` during data bit 3 of frame 0x77 → `busy`=0 next cycle, no strobe. The next full frame 0x88 is received correctly.
- Assert `rst_n` during DATA of frame 0xC3 → all outputs at reset values within 1 clk, asynchronously. The subsequent frame 0x24 is received with `rx_error`=0.
